cr16_regfile_ctrl: RTL and testbench
====================================

# cr16_regfile_ctrl

Write-port controller for the CR16 register file. It shares the file's single write port between the ALU writeback and memory-load writeback requesters using round-robin arbitration. It also runs a clear sequence that zeroes all registers one by one. It drives the file's data bus and one-hot enable from registered outputs and sits directly in front of `cr16_regfile` in the datapath.

## Interface
- `DATA_WIDTH`, 16, register and bus width.
- `REG_COUNT`, 16, number of registers; the enable is one-hot over this count.
- `I_CLK`  in  1  clock; all state updates on the rising edge.
- `I_RESET`  in  1  asynchronous, active-high reset.
- `I_ALU_VALID`  in  1  ALU write request; held until accepted.
- `I_ALU_ADDR`  in  4  ALU destination register index.
- `I_ALU_DATA`  in  DATA_WIDTH  ALU write data.
- `O_ALU_READY`  out  1  ALU request accepted this cycle.
- `I_MEM_VALID`  in  1  memory-load write request; held until accepted.
- `I_MEM_ADDR`  in  4  load destination register index.
- `I_MEM_DATA`  in  DATA_WIDTH  load write data.
- `O_MEM_READY`  out  1  load request accepted this cycle.
- `I_CLEAR`  in  1  single-cycle pulse that starts the clear sequence.
- `O_CLEAR_BUSY`  out  1  high while the clear sequence runs.
- `O_REG_BUS`  out  DATA_WIDTH  to the register file's `I_REG_BUS`.
- `O_REG_ENABLE`  out  REG_COUNT  to the register file's `I_REG_ENABLE`; one-hot or all zero.

## Operation
- Two states, IDLE and CLEAR. Reset enters IDLE.
- Handshake: a transfer occurs when VALID and READY are both high at a rising edge.
  - READY is combinational from the VALID inputs and the arbiter state.
  - Requesters must hold ADDR and DATA stable while VALID is high.
- IDLE arbitration:
  - If only one VALID is high, that requester gets READY.
  - If both are high, the one named by the `favor` bit gets READY. `favor` resets to ALU.
  - After any grant, `favor` points to the requester that was not granted.
  - The loser keeps VALID high and is granted next cycle unless preempted by a clear.
- IDLE, `I_CLEAR` high: go to CLEAR and load the counter with 0.
  - Clear takes priority: both READYs are low in that cycle.
  - `I_CLEAR` is ignored in the CLEAR state.
- CLEAR state:
  - Each cycle, drive a write of 0 to register `counter`, then increment the counter.
  - After the write to register `REG_COUNT-1`, return to IDLE.
  - Both READYs are low throughout.
  - `O_CLEAR_BUSY` equals the state being CLEAR.
- Output mapping:
  - A granted write sets `O_REG_ENABLE` to `1 << addr` and `O_REG_BUS` to the data on the next edge.
  - With no grant and no clear write, `O_REG_ENABLE` is 0 and `O_REG_BUS` holds its last value.
- Two requests to the same register in consecutive cycles: both writes are issued, in grant order. The last write wins in the file.

## Timing
- Reset values:
  - `O_REG_ENABLE` = 0, `O_REG_BUS` = 0, `O_CLEAR_BUSY` = 0.
  - Both READYs = 0 while reset is asserted.
  - State IDLE, counter 0, `favor` = ALU.
- Write latency:
  - Request accepted at edge k.
  - `O_REG_ENABLE`/`O_REG_BUS` are valid during cycle k+1.
  - The register file captures at edge k+2.
- Throughput is one write per cycle.
- Clear sequence:
  - `I_CLEAR` sampled at edge k.
  - `O_CLEAR_BUSY` is high from edge k to edge k+16.
  - Enables step through r0…r15 during cycles k+2 to k+17.
  - The first request can be accepted in the cycle after `O_CLEAR_BUSY` falls.
- Reset asserted mid-clear or mid-write: outputs return to reset values immediately and asynchronously. A partial clear is abandoned.

## Structure
- Shared package `cr16_pkg` holds:
  - `CR16_DATA_WIDTH` and `CR16_REG_COUNT`.
  - The state encoding: IDLE=0, CLEAR=1.
  - The requester IDs: ALU=0, MEM=1.
- One natural sub-module, `cr16_rr_arb2`: the two-input round-robin arbiter with the `favor` flop, producing grant and READY.
- The output registers and the CLEAR FSM stay in `cr16_regfile_ctrl`.
- The bench instantiates the controller driving a real `cr16_regfile`, with that file's active-low reset tied to `!I_RESET`.

## Test plan
- Single write: ALU valid, addr 3, data 0x1234, MEM idle. Require:
  - READY high in the same cycle.
  - `O_REG_ENABLE` = 0x0008 and `O_REG_BUS` = 0x1234 one cycle later.
  - The file's r3 = 0x1234 one cycle after that.
- Contention: ALU (addr 1, 0xAAAA) and MEM (addr 2, 0x5555) both valid from reset. Require:
  - The ALU is granted first, then MEM.
  - r1 = 0xAAAA and r2 = 0x5555.
- Fairness: both held valid for 8 cycles. Require grants alternating ALU, MEM, ALU, …, with exactly 4 grants each.
- Same-register write: ALU writes r5 = 0x0001, then MEM writes r5 = 0x0002 in the next cycle. Require final r5 = 0x0002.
- Clear: fill r0–r15 with 0xFFFF, then pulse `I_CLEAR` with ALU valid. Require:
  - `O_CLEAR_BUSY` high for 16 cycles.
  - `O_ALU_READY` low throughout, and the ALU granted after the clear.
  - All other registers = 0.
- Reset mid-clear: assert `I_RESET` at clear step 7. Require:
  - `O_REG_ENABLE` = 0 and `O_CLEAR_BUSY` = 0 immediately.
  - After release, the state is IDLE and the next grant goes to the ALU.

Source files
------------

// File: rtl/cr16_pkg.sv
// Shared constants and encodings for the CR16 register-file write path.
// Used by the write-port controller, its arbiter and the register file.
package cr16_pkg;

   localparam int CR16_DATA_WIDTH = 16;
   localparam int CR16_REG_COUNT  = 16;
   localparam int CR16_ADDR_WIDTH = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } cr16_state_e;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } cr16_req_e;

endpackage

// File: rtl/cr16_regfile.sv
// CR16 register file: one-hot write enables with a shared write bus,
// plus a combinational read port.
module cr16_regfile
   import cr16_pkg::*;
#(
   parameter int DATA_WIDTH = CR16_DATA_WIDTH,
   parameter int REG_COUNT  = CR16_REG_COUNT
) (
   input  logic                         I_CLK,
   input  logic                         I_RESET_N,
   input  logic [DATA_WIDTH-1:0]        I_REG_BUS,
   input  logic [REG_COUNT-1:0]         I_REG_ENABLE,
   input  logic [$clog2(REG_COUNT)-1:0] I_RD_ADDR,
   output logic [DATA_WIDTH-1:0]        O_RD_DATA
);

   logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];

   always_ff @(posedge I_CLK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < REG_COUNT; i++) begin
            if (I_REG_ENABLE[i]) begin
               regs_q[i] <= I_REG_BUS;
            end
         end
      end
   end

   assign O_RD_DATA = regs_q[I_RD_ADDR];

endmodule

// File: rtl/cr16_rr_arb2.sv
// Two-input round-robin arbiter for the register-file write port.
// The favor flop remembers which requester wins the next tie.
module cr16_rr_arb2
   import cr16_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic enable_i,
   input  logic aluValid_i,
   input  logic memValid_i,
   output logic aluReady_o,
   output logic memReady_o
);

   cr16_req_e favor_q, favor_d;
   logic aluGrant, memGrant;

   always_comb begin
      aluGrant = 1'b0;
      memGrant = 1'b0;
      if (enable_i) begin
         if (aluValid_i && memValid_i) begin
            aluGrant = (favor_q == REQ_ALU);
            memGrant = (favor_q == REQ_MEM);
         end else begin
            aluGrant = aluValid_i;
            memGrant = memValid_i;
         end
      end
   end

   // The requester that just lost (or did not ask) is favored next time.
   always_comb begin
      favor_d = favor_q;
      if (aluGrant) begin
         favor_d = REQ_MEM;
      end else if (memGrant) begin
         favor_d = REQ_ALU;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         favor_q <= REQ_ALU;
      end else begin
         favor_q <= favor_d;
      end
   end

   assign aluReady_o = aluGrant;
   assign memReady_o = memGrant;

endmodule

// File: rtl/cr16_regfile_ctrl.sv
// Write-port controller for the CR16 register file: round-robin sharing of
// the single write port between ALU and load writeback, plus a clear sequence.
module cr16_regfile_ctrl
   import cr16_pkg::*;
#(
   parameter int DATA_WIDTH = CR16_DATA_WIDTH,
   parameter int REG_COUNT  = CR16_REG_COUNT
) (
   input  logic                       I_CLK,
   input  logic                       I_RESET,
   input  logic                       I_ALU_VALID,
   input  logic [CR16_ADDR_WIDTH-1:0] I_ALU_ADDR,
   input  logic [DATA_WIDTH-1:0]      I_ALU_DATA,
   output logic                       O_ALU_READY,
   input  logic                       I_MEM_VALID,
   input  logic [CR16_ADDR_WIDTH-1:0] I_MEM_ADDR,
   input  logic [DATA_WIDTH-1:0]      I_MEM_DATA,
   output logic                       O_MEM_READY,
   input  logic                       I_CLEAR,
   output logic                       O_CLEAR_BUSY,
   output logic [DATA_WIDTH-1:0]      O_REG_BUS,
   output logic [REG_COUNT-1:0]       O_REG_ENABLE
);

   localparam int CNT_W = $clog2(REG_COUNT);
   localparam logic [CNT_W-1:0] LAST_REG = CNT_W'(REG_COUNT - 1);

   cr16_state_e           state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [REG_COUNT-1:0]  regEnable_q, regEnable_d;
   logic [DATA_WIDTH-1:0] regBus_q, regBus_d;
   logic                  arbEnable;
   logic                  aluReady;
   logic                  memReady;

   // A clear request pre-empts any grant in the same cycle; reset blocks both.
   assign arbEnable = (state_q == IDLE) && !I_CLEAR && !I_RESET;

   cr16_rr_arb2 u_arb (
      .clk_i      (I_CLK),
      .rst_i      (I_RESET),
      .enable_i   (arbEnable),
      .aluValid_i (I_ALU_VALID),
      .memValid_i (I_MEM_VALID),
      .aluReady_o (aluReady),
      .memReady_o (memReady)
   );

   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (I_CLEAR) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_REG) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The bus keeps its last value when nothing is written.
   always_comb begin
      regEnable_d = '0;
      regBus_d    = regBus_q;
      if (state_q == CLEAR) begin
         regEnable_d = REG_COUNT'(1) << cnt_q;
         regBus_d    = '0;
      end else if (aluReady) begin
         regEnable_d = REG_COUNT'(1) << I_ALU_ADDR;
         regBus_d    = I_ALU_DATA;
      end else if (memReady) begin
         regEnable_d = REG_COUNT'(1) << I_MEM_ADDR;
         regBus_d    = I_MEM_DATA;
      end
   end

   always_ff @(posedge I_CLK or posedge I_RESET) begin
      if (I_RESET) begin
         cnt_q       <= '0;
         regEnable_q <= '0;
         regBus_q    <= '0;
      end else begin
         cnt_q       <= cnt_d;
         regEnable_q <= regEnable_d;
         regBus_q    <= regBus_d;
      end
   end

   assign O_ALU_READY  = aluReady;
   assign O_MEM_READY  = memReady;
   assign O_CLEAR_BUSY = (state_q == CLEAR);
   assign O_REG_BUS    = regBus_q;
   assign O_REG_ENABLE = regEnable_q;

endmodule

// File: tb/tb_cr16_regfile_ctrl.sv
// Directed bench for cr16_regfile_ctrl driving a real cr16_regfile.
// Expected values are hand-computed constants for each scenario.
module tb_cr16_regfile_ctrl;
   import cr16_pkg::*;

   localparam int DW = CR16_DATA_WIDTH;
   localparam int RC = CR16_REG_COUNT;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          aluValid = 1'b0;
   logic [3:0]    aluAddr = '0;
   logic [DW-1:0] aluData = '0;
   logic          aluReady;
   logic          memValid = 1'b0;
   logic [3:0]    memAddr = '0;
   logic [DW-1:0] memData = '0;
   logic          memReady;
   logic          clearPulse = 1'b0;
   logic          clearBusy;
   logic [DW-1:0] regBus;
   logic [RC-1:0] regEnable;
   logic [3:0]    rdAddr = '0;
   logic [DW-1:0] rdData;

   int testCount = 0;
   int failCount = 0;

   always #5 clk = ~clk;

   cr16_regfile_ctrl dut (
      .I_CLK        (clk),
      .I_RESET      (reset),
      .I_ALU_VALID  (aluValid),
      .I_ALU_ADDR   (aluAddr),
      .I_ALU_DATA   (aluData),
      .O_ALU_READY  (aluReady),
      .I_MEM_VALID  (memValid),
      .I_MEM_ADDR   (memAddr),
      .I_MEM_DATA   (memData),
      .O_MEM_READY  (memReady),
      .I_CLEAR      (clearPulse),
      .O_CLEAR_BUSY (clearBusy),
      .O_REG_BUS    (regBus),
      .O_REG_ENABLE (regEnable)
   );

   cr16_regfile regfile (
      .I_CLK        (clk),
      .I_RESET_N    (!reset),
      .I_REG_BUS    (regBus),
      .I_REG_ENABLE (regEnable),
      .I_RD_ADDR    (rdAddr),
      .O_RD_DATA    (rdData)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic aV, input logic [3:0] aA, input logic [DW-1:0] aD,
                                input logic mV, input logic [3:0] mA, input logic [DW-1:0] mD,
                                input logic clr);
      aluValid   = aV;
      aluAddr    = aA;
      aluData    = aD;
      memValid   = mV;
      memAddr    = mA;
      memData    = mD;
      clearPulse = clr;
      #1;
   endtask

   task automatic readReg(input int idx, output logic [DW-1:0] val);
      rdAddr = 4'(idx);
      #1;
      val = rdData;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [DW-1:0] val;
      logic [RC-1:0] expEn;
      int aluGrants, memGrants;
      int busyCycles, readyDuringBusy, stepErrors, grantAt, nonZero;

      // Reset state, with both requesters asking to prove READY is held low
      applyStimulus(1'b1, 4'd0, 16'h0, 1'b1, 4'd0, 16'h0, 1'b0);
      checkOutput("rstAluReady", 32'(aluReady), 32'd0);
      checkOutput("rstMemReady", 32'(memReady), 32'd0);
      checkOutput("rstEnable", 32'(regEnable), 32'd0);
      checkOutput("rstBus", 32'(regBus), 32'd0);
      checkOutput("rstBusy", 32'(clearBusy), 32'd0);
      tick();
      tick();
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);
      reset = 1'b0;
      tick();

      // Single ALU write to r3
      applyStimulus(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0, 1'b0);
      checkOutput("singleAluReady", 32'(aluReady), 32'd1);
      checkOutput("singleMemReady", 32'(memReady), 32'd0);
      tick();
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);
      checkOutput("singleEnable", 32'(regEnable), 32'h0008);
      checkOutput("singleBus", 32'(regBus), 32'h1234);
      tick();
      checkOutput("singleEnableOff", 32'(regEnable), 32'd0);
      checkOutput("singleBusHold", 32'(regBus), 32'h1234);
      readReg(3, val);
      checkOutput("singleR3", 32'(val), 32'h1234);

      // Contention straight out of reset: ALU first, then MEM
      reset = 1'b1;
      applyStimulus(1'b1, 4'd1, 16'hAAAA, 1'b1, 4'd2, 16'h5555, 1'b0);
      tick();
      reset = 1'b0;
      #1;
      checkOutput("contAluFirst", 32'(aluReady), 32'd1);
      checkOutput("contMemWaits", 32'(memReady), 32'd0);
      tick();
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd2, 16'h5555, 1'b0);
      checkOutput("contMemSecond", 32'(memReady), 32'd1);
      checkOutput("contEnable1", 32'(regEnable), 32'h0002);
      checkOutput("contBus1", 32'(regBus), 32'hAAAA);
      tick();
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);
      checkOutput("contEnable2", 32'(regEnable), 32'h0004);
      checkOutput("contBus2", 32'(regBus), 32'h5555);
      tick();
      readReg(1, val);
      checkOutput("contR1", 32'(val), 32'hAAAA);
      readReg(2, val);
      checkOutput("contR2", 32'(val), 32'h5555);

      // Fairness: both held valid for 8 cycles
      tick();
      aluGrants = 0;
      memGrants = 0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 4'd6, DW'(i), 1'b1, 4'd7, DW'(16'h100 + i), 1'b0);
         checkOutput($sformatf("fairGrant%0d", i), 32'({aluReady, memReady}),
                     (i % 2 == 0) ? 32'b10 : 32'b01);
         if (aluReady) aluGrants++;
         if (memReady) memGrants++;
         tick();
      end
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);
      checkOutput("fairAluCount", 32'(aluGrants), 32'd4);
      checkOutput("fairMemCount", 32'(memGrants), 32'd4);
      tick();

      // Same register written by ALU then MEM on consecutive cycles
      applyStimulus(1'b1, 4'd5, 16'h0001, 1'b0, 4'd0, 16'h0, 1'b0);
      checkOutput("sameAluReady", 32'(aluReady), 32'd1);
      tick();
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 16'h0002, 1'b0);
      checkOutput("sameMemReady", 32'(memReady), 32'd1);
      tick();
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);
      checkOutput("sameEnable", 32'(regEnable), 32'h0020);
      checkOutput("sameBus", 32'(regBus), 32'h0002);
      tick();
      readReg(5, val);
      checkOutput("sameR5", 32'(val), 32'h0002);

      // Fill every register with 0xFFFF
      tick();
      for (int i = 0; i < RC; i++) begin
         applyStimulus(1'b1, 4'(i), 16'hFFFF, 1'b0, 4'd0, 16'h0, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);
      tick();
      readReg(0, val);
      checkOutput("fillR0", 32'(val), 32'hFFFF);
      readReg(15, val);
      checkOutput("fillR15", 32'(val), 32'hFFFF);
      tick();

      // Clear pulse with ALU waiting; clear wins that cycle
      applyStimulus(1'b1, 4'd9, 16'hBEEF, 1'b0, 4'd0, 16'h0, 1'b1);
      checkOutput("clearPreempt", 32'(aluReady), 32'd0);
      tick();
      applyStimulus(1'b1, 4'd9, 16'hBEEF, 1'b0, 4'd0, 16'h0, 1'b0);
      busyCycles = 0;
      readyDuringBusy = 0;
      stepErrors = 0;
      grantAt = -1;
      for (int j = 0; j < 40; j++) begin
         expEn = '0;
         if (j > 0) expEn = RC'(1) << (j - 1);
         if (j <= 16 && regEnable !== expEn) stepErrors++;
         if (clearBusy) begin
            busyCycles++;
            if (aluReady) readyDuringBusy++;
         end else if (aluReady) begin
            grantAt = j;
            break;
         end
         tick();
      end
      checkOutput("clearBusyCycles", 32'(busyCycles), 32'd16);
      checkOutput("clearReadyLow", 32'(readyDuringBusy), 32'd0);
      checkOutput("clearEnableSteps", 32'(stepErrors), 32'd0);
      checkOutput("clearGrantAt", 32'(grantAt), 32'd16);
      tick();
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);
      tick();
      tick();
      nonZero = 0;
      for (int i = 0; i < RC; i++) begin
         readReg(i, val);
         if (i != 9 && val !== '0) nonZero++;
      end
      checkOutput("clearZeros", 32'(nonZero), 32'd0);
      readReg(9, val);
      checkOutput("clearR9", 32'(val), 32'hBEEF);
      tick();

      // Reset at clear step 7; favor currently points at MEM
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1);
      tick();
      applyStimulus(1'b1, 4'd4, 16'h0A0A, 1'b1, 4'd8, 16'h0B0B, 1'b0);
      repeat (7) tick();
      checkOutput("midClearBusy", 32'(clearBusy), 32'd1);
      checkOutput("midClearEnable", 32'(regEnable), 32'h0040);
      reset = 1'b1;
      #1;
      checkOutput("midRstEnable", 32'(regEnable), 32'd0);
      checkOutput("midRstBusy", 32'(clearBusy), 32'd0);
      checkOutput("midRstBus", 32'(regBus), 32'd0);
      checkOutput("midRstReady", 32'({aluReady, memReady}), 32'b00);
      reset = 1'b0;
      #1;
      checkOutput("postRstBusy", 32'(clearBusy), 32'd0);
      checkOutput("postRstGrant", 32'({aluReady, memReady}), 32'b10);
      tick();
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0);
      checkOutput("postRstEnable", 32'(regEnable), 32'h0010);
      checkOutput("postRstBus", 32'(regBus), 32'h0A0A);
      tick();

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
